// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 101-detector slice (serializer and detector benches).
package seq_det_pkg;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } ser_state_t;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_stream_serializer.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = seq_det_pkg::SER_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, ser_out, ser_valid, word_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, ser_out, ser_valid, word_done
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// MSB-first word serializer feeding the 101 detectors; gapless back-to-back words.
// Optional trailing even-parity bit when SERIALIZER_PARITY_EN is defined.
module bit_stream_serializer
  import seq_det_pkg::*;
#(
  parameter int unsigned WIDTH    = SER_WIDTH_DEFAULT,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  bit_stream_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             word_done_q;
  logic             ready;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  always_comb begin
    ready = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    ready = (state == S_IDLE) || (state == S_PARITY);
`else
    ready = (state == S_IDLE) || ((state == S_SHIFT) && (count == '0));
`endif
  end

  assign accept         = bus.data_valid && ready;
  assign bus.data_ready = ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.word_done  = word_done_q;

  // ready is only high in IDLE or the final serial cycle, so an accept
  // always overrides whatever that state would otherwise do next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      count       <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (accept) begin
      state       <= S_SHIFT;
      shreg       <= bus.data_in << 1;
      count       <= CNT_W'(WIDTH - 1);
      ser_out_q   <= bus.data_in[WIDTH-1];
      ser_valid_q <= 1'b1;
      word_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= ^bus.data_in;
`endif
    end else begin
      unique case (state)
        S_SHIFT: begin
          if (count != '0) begin
            shreg       <= shreg << 1;
            count       <= count - CNT_W'(1);
            ser_out_q   <= shreg[WIDTH-1];
            ser_valid_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            word_done_q <= 1'b0;
`else
            word_done_q <= (count == CNT_W'(1));
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state       <= S_PARITY;
            ser_out_q   <= parity_q;
            ser_valid_q <= 1'b1;
            word_done_q <= 1'b1;
`else
            state       <= S_IDLE;
            shreg       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`endif
          end
        end
        default: begin
          state       <= S_IDLE;
          shreg       <= '0;
          count       <= '0;
          ser_out_q   <= IDLE_BIT;
          ser_valid_q <= 1'b0;
          word_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer (vector table, corner sequences, random vs. queue model).
module tb_bit_stream_serializer;
  import seq_det_pkg::*;

  localparam int unsigned W = SER_WIDTH_DEFAULT;
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_bits;  // expected serial order, first bit at MSB
    logic         exp_par;
  } vec_t;

  typedef struct packed {
    logic b;
    logic done;
  } obit_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic cap[$];

  bit_stream_serializer_if #(.WIDTH(W)) bus ();

  bit_stream_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [W-1:0] eb, input logic ep, input int c);
    if (c < int'(W)) return eb[W-1-c];
    return ep;
  endfunction

  function automatic int count101(input logic s[$]);
    int n = 0;
    for (int i = 2; i < s.size(); i++)
      if (s[i-2] == 1'b1 && s[i-1] == 1'b0 && s[i] == 1'b1) n++;
    return n;
  endfunction

  task automatic chk_idle(input string name);
    chk({name, " idle ser_out"}, bus.ser_out, 1'b0);
    chk({name, " idle ser_valid"}, bus.ser_valid, 1'b0);
    chk({name, " idle word_done"}, bus.word_done, 1'b0);
    chk({name, " idle ready"}, bus.data_ready, 1'b1);
  endtask

  task automatic send_word(input string name, input logic [W-1:0] w,
                           input logic [W-1:0] eb, input logic ep);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    bus.data_in    = W'($urandom);
    for (int c = 0; c < int'(NB); c++) begin
      chk({name, " ser_out"}, bus.ser_out, exp_bit(eb, ep, c));
      chk({name, " ser_valid"}, bus.ser_valid, 1'b1);
      chk({name, " word_done"}, bus.word_done, c == int'(NB) - 1);
      chk({name, " ready"}, bus.data_ready, c == int'(NB) - 1);
      step();
    end
    chk_idle(name);
  endtask

  task automatic run_b2b(input string name, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] wd;
    cap.delete();
    bus.data_in    = w0;
    bus.data_valid = 1'b1;
    step();
    bus.data_in = w1;
    for (int c = 0; c < 2 * int'(NB); c++) begin
      if (c == int'(NB)) begin
        bus.data_valid = 1'b0;
        bus.data_in    = W'($urandom);
      end
      wd = (c < int'(NB)) ? w0 : w1;
      if (bus.ser_valid) cap.push_back(bus.ser_out);
      chk({name, " ser_out"}, bus.ser_out, exp_bit(wd, ^wd, c % int'(NB)));
      chk({name, " ser_valid"}, bus.ser_valid, 1'b1);
      chk({name, " word_done"}, bus.word_done, (c % int'(NB)) == int'(NB) - 1);
      chk({name, " ready"}, bus.data_ready, (c % int'(NB)) == int'(NB) - 1);
      step();
    end
    chk_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs[8];
    obit_t q[$];
    obit_t cur;
    logic  exp_s[$];
    logic  v, mr;
    logic [W-1:0] d;

    vecs[0] = '{word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0};
    vecs[1] = '{word: 8'h5A, exp_bits: 8'b0101_1010, exp_par: 1'b0};
    vecs[2] = '{word: 8'h07, exp_bits: 8'b0000_0111, exp_par: 1'b1};
    vecs[3] = '{word: 8'h03, exp_bits: 8'b0000_0011, exp_par: 1'b0};
    vecs[4] = '{word: 8'hFF, exp_bits: 8'b1111_1111, exp_par: 1'b0};
    vecs[5] = '{word: 8'h80, exp_bits: 8'b1000_0000, exp_par: 1'b1};
    vecs[6] = '{word: 8'h00, exp_bits: 8'b0000_0000, exp_par: 1'b0};
    vecs[7] = '{word: 8'h01, exp_bits: 8'b0000_0001, exp_par: 1'b1};

    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_idle("post-reset");

    foreach (vecs[i]) send_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_bits, vecs[i].exp_par);

    run_b2b("b2b A5/5A", 8'hA5, 8'h5A);

    // boundary-spanning 101: detector count over the captured stream
    run_b2b("b2b 05/40", 8'h05, 8'h40);
    exp_s.delete();
    foreach (vecs[0].word[i]) begin end
    for (int i = int'(W) - 1; i >= 0; i--) exp_s.push_back(W'(8'h05) >> i & W'(1));
`ifdef SERIALIZER_PARITY_EN
    exp_s.push_back(1'b0);
`endif
    for (int i = int'(W) - 1; i >= 0; i--) exp_s.push_back(W'(8'h40) >> i & W'(1));
`ifdef SERIALIZER_PARITY_EN
    exp_s.push_back(1'b1);
`endif
    chk("101 stream length", cap.size(), exp_s.size());
    chk("101 count", count101(cap), count101(exp_s));

    // asynchronous reset three bits into a word
    bus.data_in    = 8'hFF;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    step();
    step();
    chk("pre-reset ser_valid", bus.ser_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_idle("mid-word reset");
    step();
    chk("reset hold word_done", bus.word_done, 1'b0);
    chk("reset hold ser_valid", bus.ser_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    send_word("after reset 81", 8'h81, 8'b1000_0001, 1'b0);

    // randomized traffic against a queue of pending output cycles
    q.delete();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      bus.data_valid = v;
      bus.data_in    = d;
      mr  = (q.size() <= 1);
      cur = (q.size() > 0) ? q[0] : obit_t'('0);
      chk("rnd ser_out", bus.ser_out, cur.b);
      chk("rnd ser_valid", bus.ser_valid, q.size() > 0);
      chk("rnd word_done", bus.word_done, cur.done);
      chk("rnd ready", bus.data_ready, mr);
      step();
      if (q.size() > 0) void'(q.pop_front());
      if (v && mr) begin
`ifdef SERIALIZER_PARITY_EN
        for (int i = int'(W) - 1; i >= 0; i--) q.push_back('{b: d[i], done: 1'b0});
        q.push_back('{b: ^d, done: 1'b1});
`else
        for (int i = int'(W) - 1; i >= 0; i--) q.push_back('{b: d[i], done: i == 0});
`endif
      end
    end
    bus.data_valid = 1'b0;
    for (int n = 0; n < int'(NB) + 1; n++) step();
    chk_idle("rnd drain");

    // no valid: random data must be ignored
    for (int n = 0; n < 20; n++) begin
      bus.data_in = W'($urandom);
      step();
      chk("novalid ser_valid", bus.ser_valid, 1'b0);
      chk("novalid ready", bus.data_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
